// File: rtl/lut_sweep_ctrl.sv
// Sweeps the select lines of an 8:1 mux through codes 0..7, samples its output
// after a settle window per code, and compares the result to a golden truth table.
module lut_sweep_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       y_in,
    output logic [2:0] abc,
    output logic       sn_n,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic       sn_n_q, sn_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] captured_q, captured_d;
    logic [7:0] exp_q, exp_d;
    logic [2:0] fail_idx_q, fail_idx_d;

    logic [7:0] mism;
    logic [2:0] first_idx;
    logic [3:0] cnt_inc;

    // Lowest mismatching code wins, so scan from the top down and let lower bits overwrite.
    always_comb begin
        mism      = captured_q ^ exp_q;
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mism[i]) begin
                first_idx = 3'(i);
            end
        end
    end

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        abc_d      = abc_q;
        sn_n_d     = sn_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        captured_d = captured_q;
        exp_d      = exp_q;
        fail_idx_d = fail_idx_q;

        case (state_q)
            IDLE: begin
                abc_d  = 3'd0;
                sn_n_d = 1'b1;
                busy_d = 1'b0;
                if (start && !abort) begin
                    exp_d      = expected;
                    captured_d = 8'd0;
                    pass_d     = 1'b0;
                    fail_idx_d = 3'd0;
                    sn_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == SETTLE_LIM) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                captured_d[abc_q] = y_in;
                if (abc_q != 3'd7) begin
                    abc_d   = abc_q + 3'd1;
                    cnt_d   = 4'd0;
                    state_d = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                abc_d      = 3'd0;
                sn_n_d     = 1'b1;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                pass_d     = (captured_q == exp_q);
                fail_idx_d = (captured_q == exp_q) ? 3'd0 : first_idx;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancelling keeps the partially captured table for debug but drops the verdict.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            cnt_d      = 4'd0;
            abc_d      = 3'd0;
            sn_n_d     = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            fail_idx_d = 3'd0;
            captured_d = captured_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            abc_q      <= 3'd0;
            sn_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= 8'd0;
            exp_q      <= 8'd0;
            fail_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            abc_q      <= abc_d;
            sn_n_q     <= sn_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            exp_q      <= exp_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign abc      = abc_q;
    assign sn_n     = sn_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = captured_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Scoreboard bench for lut_sweep_ctrl: one instance with SETTLE_CYC=2 and one with
// SETTLE_CYC=0, each driving a mux model that produces truth table 0x96.
module tb_lut_sweep_ctrl;

    localparam int S2 = 2;
    localparam int S0 = 0;

    typedef struct {
        logic [7:0] cap;
        logic       pass;
        logic [2:0] fidx;
        int         start_cyc;
        int         lat;
    } sb_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] pattern = 8'h96;

    logic       start2, abort2, y2, sn_n2, busy2, done2, pass2;
    logic [7:0] exp2, cap2;
    logic [2:0] abc2, fidx2;

    logic       start0, abort0, y0, sn_n0, busy0, done0, pass0;
    logic [7:0] exp0, cap0;
    logic [2:0] abc0, fidx0;

    sb_t sb2[$];
    sb_t sb0[$];

    lut_sweep_ctrl #(.SETTLE_CYC(S2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .expected(exp2), .y_in(y2), .abc(abc2), .sn_n(sn_n2), .busy(busy2),
        .done(done2), .pass(pass2), .captured(cap2), .fail_idx(fidx2)
    );

    lut_sweep_ctrl #(.SETTLE_CYC(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .expected(exp0), .y_in(y0), .abc(abc0), .sn_n(sn_n0), .busy(busy0),
        .done(done0), .pass(pass0), .captured(cap0), .fail_idx(fidx0)
    );

    // Mux model: disabled strobe forces the output high.
    assign y2 = sn_n2 ? 1'b1 : pattern[abc2];
    assign y0 = sn_n0 ? 1'b1 : pattern[abc0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] want);
        checks++;
        if (actual !== want) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, want);
        end
    endtask

    function automatic logic [2:0] calcFailIdx(input logic [7:0] cap, input logic [7:0] exp);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && (cap[i] != exp[i])) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Drives one start pulse and pushes the model's verdict for that sweep.
    task automatic applyStimulus(input bit useZero, input logic [7:0] exp);
        sb_t e;
        if (useZero) begin
            exp0   = exp;
            start0 = 1'b1;
        end else begin
            exp2   = exp;
            start2 = 1'b1;
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        e.cap       = pattern;
        e.pass      = (pattern == exp);
        e.fidx      = e.pass ? 3'd0 : calcFailIdx(pattern, exp);
        e.start_cyc = cyc;
        e.lat       = 8 * ((useZero ? S0 : S2) + 1) + 1;
        if (useZero) sb0.push_back(e);
        else sb2.push_back(e);
    endtask

    task automatic waitDrain(input bit useZero, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if ((useZero ? sb0.size() : sb2.size()) == 0) break;
        end
        if (useZero) begin
            if (sb0.size() != 0) begin
                checkOutput("dut0_timeout", sb0.size(), 0);
                sb0.delete();
            end
        end else begin
            if (sb2.size() != 0) begin
                checkOutput("dut2_timeout", sb2.size(), 0);
                sb2.delete();
            end
        end
    endtask

    task automatic checkNoDone(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
        end
        checkOutput(tag, seen, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && done2) begin
            if (sb2.size() == 0) begin
                checkOutput("dut2_unexpected_done", 1, 0);
            end else begin
                sb_t e;
                e = sb2.pop_front();
                checkOutput("dut2_captured", cap2, e.cap);
                checkOutput("dut2_pass", pass2, e.pass);
                checkOutput("dut2_fail_idx", fidx2, e.fidx);
                checkOutput("dut2_latency", cyc - e.start_cyc, e.lat);
                checkOutput("dut2_sn_n_after", sn_n2, 1'b1);
                checkOutput("dut2_busy_after", busy2, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (sb0.size() == 0) begin
                checkOutput("dut0_unexpected_done", 1, 0);
            end else begin
                sb_t e;
                e = sb0.pop_front();
                checkOutput("dut0_captured", cap0, e.cap);
                checkOutput("dut0_pass", pass0, e.pass);
                checkOutput("dut0_fail_idx", fidx0, e.fidx);
                checkOutput("dut0_latency", cyc - e.start_cyc, e.lat);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; exp2 = 8'h00;
        start0 = 1'b0; abort0 = 1'b0; exp0 = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_abc", abc2, 3'd0);
        checkOutput("rst_sn_n", sn_n2, 1'b1);
        checkOutput("rst_busy", busy2, 1'b0);
        checkOutput("rst_done", done2, 1'b0);
        checkOutput("rst_pass", pass2, 1'b0);
        checkOutput("rst_fail_idx", fidx2, 3'd0);
        checkOutput("rst_captured", cap2, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // First start right after reset release, matching golden table.
        applyStimulus(1'b0, 8'h96);
        checkOutput("first_start_busy", busy2, 1'b1);
        checkOutput("first_start_sn_n", sn_n2, 1'b0);
        waitDrain(1'b0, 40);

        applyStimulus(1'b0, 8'h16);
        waitDrain(1'b0, 40);
        applyStimulus(1'b0, 8'h97);
        waitDrain(1'b0, 40);
        applyStimulus(1'b0, 8'h9E);
        waitDrain(1'b0, 40);
        checkOutput("idle_abc", abc2, 3'd0);
        checkOutput("idle_sn_n", sn_n2, 1'b1);

        // Zero settle: one code per cycle.
        applyStimulus(1'b1, 8'h96);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("dut0_abc_step%0d", k), abc0, k);
            @(posedge clk);
            #1;
        end
        waitDrain(1'b1, 20);

        // Start re-pulsed mid-sweep with a different table must be ignored.
        applyStimulus(1'b0, 8'h96);
        repeat (9) @(posedge clk);
        #1;
        exp2   = 8'h00;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        waitDrain(1'b0, 40);

        // Abort and start together in IDLE: abort wins.
        start2 = 1'b1;
        abort2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        abort2 = 1'b0;
        checkOutput("abort_start_busy", busy2, 1'b0);
        checkOutput("abort_start_sn_n", sn_n2, 1'b1);

        // Abort while code 3 is on the select lines.
        applyStimulus(1'b0, 8'h96);
        for (int i = 0; i < 40; i++) begin
            if (abc2 == 3'd3) break;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_reach_abc3", abc2, 3'd3);
        abort2 = 1'b1;
        @(posedge clk);
        #1 abort2 = 1'b0;
        sb2.delete();
        checkOutput("abort_busy", busy2, 1'b0);
        checkOutput("abort_sn_n", sn_n2, 1'b1);
        checkOutput("abort_abc", abc2, 3'd0);
        checkOutput("abort_partial", cap2[2:0], 3'b110);
        checkOutput("abort_pass", pass2, 1'b0);
        checkNoDone("abort_no_done", 30);
        applyStimulus(1'b0, 8'h96);
        waitDrain(1'b0, 40);

        // Reset mid-sweep at cycle 12.
        applyStimulus(1'b0, 8'h96);
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        sb2.delete();
        checkOutput("midrst_abc", abc2, 3'd0);
        checkOutput("midrst_sn_n", sn_n2, 1'b1);
        checkOutput("midrst_busy", busy2, 1'b0);
        checkOutput("midrst_captured", cap2, 8'h00);
        checkOutput("midrst_fail_idx", fidx2, 3'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkNoDone("midrst_no_done", 30);
        applyStimulus(1'b0, 8'h16);
        waitDrain(1'b0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
